regfile_wb_queue: RTL and testbench

//  Writeback-side producer for the register-file write port (write_reg/write_data/regwrite).

---
 rtl/regfile_wb_queue_if.sv | 41 ++++
 rtl/regfile_wb_queue.sv | 119 +++++++++++
 tb/tb_regfile_wb_queue.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// Bus bundle for regfile_wb_queue: two result sources, drain stall, hazard lookup
// and the registered register-file write port. The DUT uses the slave modport.
interface regfile_wb_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              wb_stall;
  logic [ADDR_W-1:0] chk_reg;
  logic              chk_pending;
  logic              regwrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  wb_stall, chk_reg,
    output alu_ready, mem_ready, chk_pending,
    output regwrite, write_reg, write_data, count
  );

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output wb_stall, chk_reg,
    input  alu_ready, mem_ready, chk_pending,
    input  regwrite, write_reg, write_data, count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Writeback queue: round-robin ALU/load arbitration, DEPTH-entry FIFO, one registered
// register-file write per cycle, pending-write lookup. Option macro: WB_DISCARD_R0_EN.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  regfile_wb_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rrMem;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_writeReg;
  logic [DATA_W-1:0] r_writeData;

  logic              w_full;
  logic              w_aluGrant;
  logic              w_memGrant;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_inReg;
  logic [DATA_W-1:0] w_inData;
  logic              w_drop;
  logic              w_accept;
  logic              w_pop;
  logic              w_bypass;
  logic              w_enq;
  logic              w_chkHit;

  // The pointer only matters when both sources compete; a lone source always wins.
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_aluGrant = bus.alu_valid && !w_full && (!bus.mem_valid || !r_rrMem);
  assign w_memGrant = bus.mem_valid && !w_full && (!bus.alu_valid ||  r_rrMem);
  assign w_xfer     = w_aluGrant || w_memGrant;
  assign w_inReg    = w_memGrant ? bus.mem_reg  : bus.alu_reg;
  assign w_inData   = w_memGrant ? bus.mem_data : bus.alu_data;

`ifdef WB_DISCARD_R0_EN
  assign w_drop = w_xfer && (w_inReg == '0);
`else
  assign w_drop = 1'b0;
`endif

  assign w_accept = w_xfer && !w_drop;
  assign w_pop    = !bus.wb_stall && (r_count != '0);
  assign w_bypass = !bus.wb_stall && (r_count == '0) && w_accept;
  assign w_enq    = w_accept && !w_bypass;

  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_reg[r_wrPtr]  <= w_inReg;
      r_data[r_wrPtr] <= w_inData;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_rrMem     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
    end else begin
      if (w_enq) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Dropped transfers leave the pointer alone so they cannot steal a turn.
      if (w_accept) r_rrMem <= w_aluGrant;
      if (w_pop) begin
        r_regwrite  <= 1'b1;
        r_writeReg  <= r_reg[r_rdPtr];
        r_writeData <= r_data[r_rdPtr];
      end else if (w_bypass) begin
        r_regwrite  <= 1'b1;
        r_writeReg  <= w_inReg;
        r_writeData <= w_inData;
      end else begin
        r_regwrite  <= 1'b0;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_chkHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(i) - r_rdPtr} < r_count) && (r_reg[i] == bus.chk_reg))
        w_chkHit = 1'b1;
    end
    if (r_regwrite && (r_writeReg == bus.chk_reg))
      w_chkHit = 1'b1;
`ifdef WB_DISCARD_R0_EN
    if (bus.chk_reg == '0)
      w_chkHit = 1'b0;
`endif
  end

  assign bus.alu_ready   = w_aluGrant;
  assign bus.mem_ready   = w_memGrant;
  assign bus.chk_pending = w_chkHit;
  assign bus.regwrite    = r_regwrite;
  assign bus.write_reg   = r_writeReg;
  assign bus.write_data  = r_writeData;
  assign bus.count       = r_count;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: reset, bypass latency, round-robin, full/stall
// drain, pending lookup, async reset mid-operation and register-0 handling.
module tb_regfile_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rstN;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idleInputs();
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    bus.wb_stall  = 1'b0; bus.chk_reg = '0;
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic pulseReset();
    rstN = 1'b0;
    idleInputs();
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    idleInputs();
    @(negedge clk);
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("[TB] FAIL reset_regwrite got=%0b want=0", bus.regwrite); end
    total++; if (bus.write_reg !== 5'd0) begin bad++; $display("[TB] FAIL reset_write_reg got=%0d want=0", bus.write_reg); end
    total++; if (bus.write_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_write_data got=%h want=0", bus.write_data); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", bus.count); end
    rstN = 1'b1;
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_alu_ready got=%0b want=1", bus.alu_ready); end
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("[TB] FAIL single_mem_ready got=%0b want=0", bus.mem_ready); end
    @(posedge clk); #1;
    total++; if (bus.regwrite !== 1'b1) begin bad++; $display("[TB] FAIL single_regwrite got=%0b want=1", bus.regwrite); end
    total++; if (bus.write_reg !== 5'd5) begin bad++; $display("[TB] FAIL single_write_reg got=%0d want=5", bus.write_reg); end
    total++; if (bus.write_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_write_data got=%h want=deadbeef", bus.write_data); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("[TB] FAIL single_count got=%0d want=0", bus.count); end
    @(negedge clk);
    bus.alu_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("[TB] FAIL single_regwrite_off got=%0b want=0", bus.regwrite); end
    total++; if (bus.write_reg !== 5'd5) begin bad++; $display("[TB] FAIL single_write_reg_hold got=%0d want=5", bus.write_reg); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("[TB] FAIL single_count_after got=%0d want=0", bus.count); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int ai;
    int mi;
    logic [ADDR_W-1:0] expRegs [4];
    expRegs = '{5'd1, 5'd3, 5'd2, 5'd4};
    ai = 0; mi = 0;
    pulseReset();
    for (int k = 0; k < 4; k++) begin
      bus.alu_valid = (ai < 2);
      bus.alu_reg   = ADDR_W'(ai + 1);
      bus.alu_data  = 32'hA000_0000 | 32'(ai + 1);
      bus.mem_valid = (mi < 2);
      bus.mem_reg   = ADDR_W'(mi + 3);
      bus.mem_data  = 32'hA000_0000 | 32'(mi + 3);
      #1;
      total++; if (bus.alu_ready !== (k % 2 == 0)) begin bad++; $display("[TB] FAIL rr_alu_ready cycle=%0d got=%0b want=%0b", k, bus.alu_ready, (k % 2 == 0)); end
      total++; if (bus.mem_ready !== (k % 2 == 1)) begin bad++; $display("[TB] FAIL rr_mem_ready cycle=%0d got=%0b want=%0b", k, bus.mem_ready, (k % 2 == 1)); end
      @(posedge clk); #1;
      total++; if (bus.regwrite !== 1'b1) begin bad++; $display("[TB] FAIL rr_regwrite cycle=%0d got=%0b want=1", k, bus.regwrite); end
      total++; if (bus.write_reg !== expRegs[k]) begin bad++; $display("[TB] FAIL rr_write_reg cycle=%0d got=%0d want=%0d", k, bus.write_reg, expRegs[k]); end
      total++; if (bus.write_data !== (32'hA000_0000 | 32'(expRegs[k]))) begin bad++; $display("[TB] FAIL rr_write_data cycle=%0d got=%h want=%h", k, bus.write_data, 32'hA000_0000 | 32'(expRegs[k])); end
      if (k % 2 == 0) ai++; else mi++;
      @(negedge clk);
    end
    idleInputs();
    @(posedge clk); #1;
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("[TB] FAIL rr_regwrite_end got=%0b want=0", bus.regwrite); end
    @(negedge clk);
  endtask

  task automatic test_stall_full();
    int expCount [5];
    expCount = '{3, 3, 2, 1, 0};
    pulseReset();
    bus.wb_stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = ADDR_W'(k); bus.alu_data = 32'(k * 16);
      #1;
      total++; if (bus.alu_ready !== (k <= 4)) begin bad++; $display("[TB] FAIL full_alu_ready push=%0d got=%0b want=%0b", k, bus.alu_ready, (k <= 4)); end
      @(posedge clk); #1;
      total++; if (bus.count !== 3'((k > 4) ? 4 : k)) begin bad++; $display("[TB] FAIL full_count push=%0d got=%0d want=%0d", k, bus.count, (k > 4) ? 4 : k); end
      total++; if (bus.regwrite !== 1'b0) begin bad++; $display("[TB] FAIL full_stall_regwrite push=%0d got=%0b want=0", k, bus.regwrite); end
      @(negedge clk);
    end
    bus.wb_stall = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j >= 2) bus.alu_valid = 1'b0;
      #1;
      if (j < 2) begin
        total++; if (bus.alu_ready !== (j == 1)) begin bad++; $display("[TB] FAIL drain_alu_ready step=%0d got=%0b want=%0b", j, bus.alu_ready, (j == 1)); end
      end
      @(posedge clk); #1;
      total++; if (bus.regwrite !== 1'b1) begin bad++; $display("[TB] FAIL drain_regwrite step=%0d got=%0b want=1", j, bus.regwrite); end
      total++; if (bus.write_reg !== ADDR_W'(j + 1)) begin bad++; $display("[TB] FAIL drain_write_reg step=%0d got=%0d want=%0d", j, bus.write_reg, j + 1); end
      total++; if (bus.write_data !== 32'((j + 1) * 16)) begin bad++; $display("[TB] FAIL drain_write_data step=%0d got=%h want=%h", j, bus.write_data, (j + 1) * 16); end
      total++; if (bus.count !== 3'(expCount[j])) begin bad++; $display("[TB] FAIL drain_count step=%0d got=%0d want=%0d", j, bus.count, expCount[j]); end
      @(negedge clk);
    end
    @(posedge clk); #1;
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("[TB] FAIL drain_regwrite_end got=%0b want=0", bus.regwrite); end
    @(negedge clk);
  endtask

  task automatic test_pending();
    pulseReset();
    bus.wb_stall = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd7; bus.alu_data = 32'd77;
    @(posedge clk); #1;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    bus.chk_reg = 5'd7;
    #1;
    total++; if (bus.chk_pending !== 1'b1) begin bad++; $display("[TB] FAIL pend_queued got=%0b want=1", bus.chk_pending); end
    bus.chk_reg = 5'd8;
    #1;
    total++; if (bus.chk_pending !== 1'b0) begin bad++; $display("[TB] FAIL pend_other got=%0b want=0", bus.chk_pending); end
    bus.wb_stall = 1'b0;
    bus.chk_reg = 5'd7;
    @(posedge clk); #1;
    total++; if (bus.regwrite !== 1'b1 || bus.write_reg !== 5'd7) begin bad++; $display("[TB] FAIL pend_write got=%0b/%0d want=1/7", bus.regwrite, bus.write_reg); end
    total++; if (bus.chk_pending !== 1'b1) begin bad++; $display("[TB] FAIL pend_outstage got=%0b want=1", bus.chk_pending); end
    @(negedge clk);
    @(posedge clk); #1;
    total++; if (bus.chk_pending !== 1'b0) begin bad++; $display("[TB] FAIL pend_retired got=%0b want=0", bus.chk_pending); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    pulseReset();
    bus.wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = ADDR_W'(10 + k); bus.alu_data = 32'(100 + k);
      @(posedge clk); #1;
      @(negedge clk);
    end
    bus.alu_valid = 1'b0;
    total++; if (bus.count !== 3'd3) begin bad++; $display("[TB] FAIL arst_queued got=%0d want=3", bus.count); end
    bus.wb_stall = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.regwrite !== 1'b1 || bus.write_reg !== 5'd10 || bus.count !== 3'd2) begin bad++; $display("[TB] FAIL arst_pre got=%0b/%0d/%0d want=1/10/2", bus.regwrite, bus.write_reg, bus.count); end
    #2;
    rstN = 1'b0;
    #1;
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("[TB] FAIL arst_regwrite got=%0b want=0", bus.regwrite); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("[TB] FAIL arst_count got=%0d want=0", bus.count); end
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++; if (bus.regwrite !== 1'b0 || bus.count !== 3'd0) begin bad++; $display("[TB] FAIL arst_after cycle=%0d got=%0b/%0d want=0/0", k, bus.regwrite, bus.count); end
    end
    @(negedge clk);
  endtask

  task automatic test_reg0();
    pulseReset();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'd55;
    bus.chk_reg = 5'd0;
    #1;
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL r0_alu_ready got=%0b want=1", bus.alu_ready); end
    @(posedge clk); #1;
`ifdef WB_DISCARD_R0_EN
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("[TB] FAIL r0_regwrite got=%0b want=0", bus.regwrite); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("[TB] FAIL r0_count got=%0d want=0", bus.count); end
    total++; if (bus.chk_pending !== 1'b0) begin bad++; $display("[TB] FAIL r0_pending got=%0b want=0", bus.chk_pending); end
`else
    total++; if (bus.regwrite !== 1'b1) begin bad++; $display("[TB] FAIL r0_regwrite got=%0b want=1", bus.regwrite); end
    total++; if (bus.write_reg !== 5'd0 || bus.write_data !== 32'd55) begin bad++; $display("[TB] FAIL r0_write got=%0d/%0d want=0/55", bus.write_reg, bus.write_data); end
    total++; if (bus.chk_pending !== 1'b1) begin bad++; $display("[TB] FAIL r0_pending got=%0b want=1", bus.chk_pending); end
`endif
    @(negedge clk);
    // The reg-0 transfer advances the turn only when it is actually written.
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = 32'd11;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd2; bus.mem_data = 32'd22;
    #1;
`ifdef WB_DISCARD_R0_EN
    total++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin bad++; $display("[TB] FAIL r0_rr got=%0b/%0b want=1/0", bus.alu_ready, bus.mem_ready); end
`else
    total++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b1) begin bad++; $display("[TB] FAIL r0_rr got=%0b/%0b want=0/1", bus.alu_ready, bus.mem_ready); end
`endif
    idleInputs();
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting regfile_wb_queue bench");
    test_reset();
    test_single_alu();
    test_round_robin();
    test_stall_full();
    test_pending();
    test_async_reset();
    test_reg0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
